mips_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, attached to the execute stage of the pipelined MIPS datapath. It replaces single-cycle ALU multiply with a parametrised, multi-cycle engine that handles MULT/MULTU/DIV/DIVU and MTHI/MTLO. It raises `busy` so the hazard unit can stall MFHI/MFLO and further mult/div issues. A branch/exception flush aborts it.

---
 rtl/mips_muldiv_pkg.sv | 21 ++
 rtl/mips_muldiv_cond_neg.sv | 15 +
 rtl/mips_muldiv.sv | 199 +++++++++++++++++++
 tb/tb_mips_muldiv.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
//   op_e    : operation codes presented on mips_muldiv.op (6 and 7 are illegal)
//   state_e : sequencer states, also visible on mips_muldiv.state_dbg
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mips_muldiv_cond_neg.sv
// Conditional two's-complement negate.
//   din  : value to pass through or negate
//   neg  : 1 -> dout = -din, 0 -> dout = din
//   dout : result (same width as din)
module muldiv_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Build option: define MIPS_MULDIV_DIV_EN to compile in the divider; without
// it DIV/DIVU are ignored like illegal ops and div_by_zero is tied low.
//
// Ports:
//   clk, reset (async, active low)
//   start/op/a/b : issue interface, sampled only in IDLE
//   flush        : abort the in-flight operation (also blocks a same-cycle issue)
//   busy         : registered, high while state != IDLE
//   done         : one-cycle pulse, hi/lo already hold the new result
//   div_by_zero  : pulses with done for a divide by zero
//   hi, lo       : architectural HI/LO
//   state_dbg    : current sequencer state (state_e encoding)
//
// Handshake: start is a single-cycle request accepted only when state is IDLE
// and flush is low; there is no ready, callers stall on busy instead.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  // acc: product high half / partial remainder; mq: multiplier / quotient.
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opnd_b;
  logic               q_sign;

  logic               is_mul_op;
  logic               is_div_op;
  logic               is_sgn_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign state_dbg = state;
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_sgn_op = (op == OP_MULT) || (op == OP_DIV);

  muldiv_cond_neg #(.WIDTH(WIDTH)) u_abs_a (
    .din(a), .neg(is_sgn_op & a[WIDTH-1]), .dout(abs_a));
  muldiv_cond_neg #(.WIDTH(WIDTH)) u_abs_b (
    .din(b), .neg(is_sgn_op & b[WIDTH-1]), .dout(abs_b));

  // Shift-add step: add multiplicand when the low multiplier bit is set, then
  // shift {sum, mq} right by one.
  assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});

  muldiv_cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .din({acc, mq}), .neg(q_sign), .dout(prod_fix));

`ifdef MIPS_MULDIV_DIV_EN
  logic               div_r;
  logic               dz_r;
  logic               r_sign;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH:0]     div_shl;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);

  // Restoring step: remainder stays below the divisor, so the WIDTH+1 bit
  // difference is negative exactly when its top bit is set.
  assign div_shl  = {acc, mq[WIDTH-1]};
  assign div_diff = div_shl - {1'b0, opnd_b};

  muldiv_cond_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .din(mq), .neg(q_sign), .dout(quo_fix));
  muldiv_cond_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .din(acc), .neg(r_sign), .dout(rem_fix));
`else
  assign is_div_op   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      opnd_b <= '0;
      q_sign <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      div_by_zero <= 1'b0;
      div_r       <= 1'b0;
      dz_r        <= 1'b0;
      r_sign      <= 1'b0;
      a_raw       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      div_by_zero <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            if (is_mul_op || is_div_op) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= CNT_W'(WIDTH);
              acc    <= '0;
              mq     <= abs_a;
              opnd_b <= abs_b;
              q_sign <= is_sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MIPS_MULDIV_DIV_EN
              div_r  <= is_div_op;
              dz_r   <= (b == '0);
              r_sign <= is_sgn_op & a[WIDTH-1];
              a_raw  <= a;
`endif
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
`ifdef MIPS_MULDIV_DIV_EN
            if (div_r) begin
              if (!div_diff[WIDTH]) begin
                acc <= div_diff[WIDTH-1:0];
                mq  <= {mq[WIDTH-2:0], 1'b1};
              end else begin
                acc <= div_shl[WIDTH-1:0];
                mq  <= {mq[WIDTH-2:0], 1'b0};
              end
            end else
`endif
            begin
              acc <= mul_sum[WIDTH:1];
              mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
            if (div_r) begin
              if (dz_r) begin
                lo          <= '1;
                hi          <= a_raw;
                div_by_zero <= 1'b1;
              end else begin
                lo <= quo_fix;
                hi <= rem_fix;
              end
            end else
`endif
            begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv (WIDTH = 32).
module tb_mips_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  // results captured by run_op
  logic [31:0] r_hi, r_lo;
  logic        r_dz, r_done_seen, r_busy_at_done, r_done_after;
  int          r_busy_cycles;

  localparam logic [2:0] C_MULT  = 3'd0;
  localparam logic [2:0] C_MULTU = 3'd1;
  localparam logic [2:0] C_DIV   = 3'd2;
  localparam logic [2:0] C_DIVU  = 3'd3;
  localparam logic [2:0] C_MTHI  = 3'd4;
  localparam logic [2:0] C_MTLO  = 3'd5;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: issue one op and wait (bounded) for done, sampling on negedges
  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    r_done_seen = 1'b0; r_busy_cycles = 0; r_busy_at_done = 1'b0;
    r_hi = '0; r_lo = '0; r_dz = 1'b0;
    @(negedge clk); op = o; a = va; b = vb; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) r_busy_cycles++;
      if (done) begin
        r_done_seen = 1'b1; r_hi = hi; r_lo = lo; r_dz = div_by_zero; r_busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk); r_done_after = done;
  endtask

  task automatic drive_mt(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk); op = o; a = v; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        div_by_zero !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b st=%0d expected all zero",
               hi, lo, busy, done, div_by_zero, state_dbg);
    end
    reset = 1'b1;
  endtask

  task automatic test_multu;
    run_op(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (r_done_seen !== 1'b1 || r_hi !== 32'hFFFFFFFE || r_lo !== 32'h00000001) begin
      failures++;
      $display("FAIL multu_max: done=%b hi=%h lo=%h expected done=1 hi=fffffffe lo=00000001",
               r_done_seen, r_hi, r_lo);
    end
    checks++;
    if (r_busy_cycles !== 33 || r_busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL multu_busy_len: busy_cycles=%0d busy_at_done=%b expected 33 and 0",
               r_busy_cycles, r_busy_at_done);
    end
    checks++;
    if (r_done_after !== 1'b0 || r_dz !== 1'b0) begin
      failures++;
      $display("FAIL multu_done_pulse: done_next=%b dz=%b expected 0 0", r_done_after, r_dz);
    end
    run_op(C_MULTU, 32'h12345678, 32'h00000010);
    checks++;
    if (r_hi !== 32'h00000001 || r_lo !== 32'h23456780) begin
      failures++;
      $display("FAIL multu_shift: hi=%h lo=%h expected 00000001 23456780", r_hi, r_lo);
    end
  endtask

  task automatic test_mult;
    run_op(C_MULT, 32'hFFFFFFFD, 32'h00000007);
    checks++;
    if (r_hi !== 32'hFFFFFFFF || r_lo !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL mult_neg: hi=%h lo=%h expected ffffffff ffffffeb", r_hi, r_lo);
    end
    run_op(C_MULT, 32'h80000000, 32'h80000000);
    checks++;
    if (r_hi !== 32'h40000000 || r_lo !== 32'h00000000) begin
      failures++;
      $display("FAIL mult_minmin: hi=%h lo=%h expected 40000000 00000000", r_hi, r_lo);
    end
  endtask

  task automatic test_div;
`ifdef MIPS_MULDIV_DIV_EN
    run_op(C_DIV, 32'hFFFFFFF9, 32'h00000002);
    checks++;
    if (r_lo !== 32'hFFFFFFFD || r_hi !== 32'hFFFFFFFF || r_dz !== 1'b0) begin
      failures++;
      $display("FAIL div_neg: lo=%h hi=%h dz=%b expected fffffffd ffffffff 0", r_lo, r_hi, r_dz);
    end
    run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (r_lo !== 32'h80000000 || r_hi !== 32'h00000000) begin
      failures++;
      $display("FAIL div_ovf: lo=%h hi=%h expected 80000000 00000000", r_lo, r_hi);
    end
    run_op(C_DIV, 32'h00000007, 32'hFFFFFFFE);
    checks++;
    if (r_lo !== 32'hFFFFFFFD || r_hi !== 32'h00000001) begin
      failures++;
      $display("FAIL div_negb: lo=%h hi=%h expected fffffffd 00000001", r_lo, r_hi);
    end
    run_op(C_DIVU, 32'd100, 32'd7);
    checks++;
    if (r_lo !== 32'd14 || r_hi !== 32'd2) begin
      failures++;
      $display("FAIL divu_basic: lo=%h hi=%h expected 0000000e 00000002", r_lo, r_hi);
    end
    run_op(C_DIVU, 32'd100, 32'd0);
    checks++;
    if (r_done_seen !== 1'b1 || r_lo !== 32'hFFFFFFFF || r_hi !== 32'd100 || r_dz !== 1'b1) begin
      failures++;
      $display("FAIL divu_zero: done=%b lo=%h hi=%h dz=%b expected 1 ffffffff 00000064 1",
               r_done_seen, r_lo, r_hi, r_dz);
    end
    checks++;
    if (div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_pulse: dz=%b expected 0 after done", div_by_zero);
    end
`else
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    run_op(C_DIVU, 32'd100, 32'd0);
    checks++;
    if (r_done_seen !== 1'b0 || r_busy_cycles !== 0 || hi !== h0 || lo !== l0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_disabled: done=%b busy_cycles=%0d hi=%h lo=%h expected 0 0 %h %h",
               r_done_seen, r_busy_cycles, hi, lo, h0, l0);
    end
    run_op(C_DIV, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (r_done_seen !== 1'b0 || r_busy_cycles !== 0 || hi !== h0 || lo !== l0) begin
      failures++;
      $display("FAIL div_disabled_signed: done=%b busy_cycles=%0d hi=%h lo=%h expected 0 0 %h %h",
               r_done_seen, r_busy_cycles, hi, lo, h0, l0);
    end
`endif
  endtask

  task automatic test_mt;
    logic [31:0] h0;
    h0 = hi;
    drive_mt(C_MTLO, 32'h00001234);
    checks++;
    if (lo !== 32'h00001234 || hi !== h0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: lo=%h hi=%h done=%b busy=%b expected 00001234 %h 0 0", lo, hi, done, busy, h0);
    end
    drive_mt(C_MTHI, 32'h0000CAFE);
    checks++;
    if (hi !== 32'h0000CAFE || lo !== 32'h00001234 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h done=%b busy=%b expected 0000cafe 00001234 0 0", hi, lo, done, busy);
    end
  endtask

  task automatic test_illegal;
    for (int k = 6; k < 8; k++) begin
      drive_mt(3'(k), 32'hDEADBEEF);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0000CAFE || lo !== 32'h00001234) begin
        failures++;
        $display("FAIL illegal_op%0d: busy=%b hi=%h lo=%h expected 0 0000cafe 00001234", k, busy, hi, lo);
      end
    end
  endtask

  task automatic test_flush;
    logic saw_done;
    drive_mt(C_MTHI, 32'h0000AAAA);
    drive_mt(C_MTLO, 32'h00005555);
    @(negedge clk); op = C_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;       // first RUN cycle
    repeat (9) @(negedge clk);          // tenth RUN cycle
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL flush_idle: busy=%b state=%0d expected 0 0", busy, state_dbg);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || hi !== 32'h0000AAAA || lo !== 32'h00005555) begin
      failures++;
      $display("FAIL flush_hold: done_seen=%b hi=%h lo=%h expected 0 0000aaaa 00005555", saw_done, hi, lo);
    end
    @(negedge clk); op = C_MULT; a = 32'd5; b = 32'd6; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL flush_start_mult: busy=%b state=%0d expected 0 0", busy, state_dbg);
    end
    @(negedge clk); op = C_MTLO; a = 32'h0000BEEF; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++;
    if (lo !== 32'h00005555) begin
      failures++;
      $display("FAIL flush_start_mtlo: lo=%h expected 00005555", lo);
    end
  endtask

  task automatic test_back_to_back;
    logic seen;
    @(negedge clk); op = C_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    // a stray MTLO while busy must be ignored
    op = C_MTLO; a = 32'h0000DEAD; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (lo !== 32'h00005555 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_while_busy: lo=%h busy=%b expected 00005555 1", lo, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
      failures++;
      $display("FAIL b2b_first: done=%b hi=%h lo=%h expected 1 00000000 0000000f", seen, hi, lo);
    end
    // issue the next op in the done cycle
    op = C_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
      failures++;
      $display("FAIL b2b_second: done=%b hi=%h lo=%h expected 1 00000000 0000002a", seen, hi, lo);
    end
  endtask

  task automatic test_async_reset;
    logic saw_done;
    drive_mt(C_MTHI, 32'h00000001);
    drive_mt(C_MTLO, 32'h00000002);
    @(negedge clk); op = C_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || state_dbg !== 2'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h state=%0d done=%b expected all zero",
               busy, hi, lo, state_dbg, done);
    end
    @(negedge clk); reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_quiet: activity=%b hi=%h lo=%h expected 0 0 0", saw_done, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_mt();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
